// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the default operand width, the controller state encoding and the
// borrow equation used by the per-bit cell.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Borrow out of a one-bit subtraction a - b - bin.
  function automatic logic borrow_next(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Ports:
//   a, b  : operand bits
//   bin   : borrow in from the previous (less significant) bit
//   d     : difference bit
//   bout  : borrow out to the next bit
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = borrow_next(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor computing a - b, one bit per clock, LSB first.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   start : begin a subtraction (only honoured while idle)
//   a, b  : minuend / subtrahend, captured when start is accepted
//   busy  : operation in progress
//   done  : one-cycle pulse, diff/bout valid
//   diff  : a - b modulo 2^WIDTH, held until the next result
//   bout  : final borrow (1 when a < b)
// All outputs come straight from flops. done and busy are registered from the
// controller state, so they trail the state by one cycle: start accepted at
// edge k gives done in the cycle after edge k+WIDTH+1, and a new start can be
// accepted in that same cycle.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] part_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             d_s;
  logic             bo_s;

  full_subtractor u_fs (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .bin  (br_r),
    .d    (d_s),
    .bout (bo_s)
  );

  // Controller next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // The last bit is processed on the edge that leaves RUN.
        if (cnt_r == LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand shifting, borrow chain, bit counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_r <= '0;
      b_sr_r <= '0;
      part_r <= '0;
      br_r   <= 1'b0;
      cnt_r  <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r <= a;
            b_sr_r <= b;
            br_r   <= 1'b0;
            cnt_r  <= '0;
          end
        end
        RUN: begin
          a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
          part_r <= {d_s, part_r[WIDTH-1:1]};
          br_r   <= bo_s;
          if (cnt_r == LAST) begin
            // Include the bit being produced this cycle in the result.
            diff_r <= {d_s, part_r[WIDTH-1:1]};
            bout_r <= bo_s;
          end else begin
            cnt_r  <= cnt_r + CW'(1);
          end
        end
        default: begin
          a_sr_r <= a_sr_r;
        end
      endcase
    end
  end

  // Status flags, registered from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_r != IDLE);
      done_r <= (state_r == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH = 8.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int total;
  int bad;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an operation from IDLE and wait for its done pulse.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [8:0] exp, input string tag);
    int n;
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_res"}, {23'd0, bout, diff}, {23'd0, exp});
  endtask

  initial begin
    int n;
    int pulses;
    logic hold_ok;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] model;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);

    // Directed vectors.
    do_op(8'h35, 8'h12, 9'h023, "v35_12");
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    do_op(8'h12, 8'h35, 9'h1DD, "v12_35");
    tick();
    do_op(8'h00, 8'h01, 9'h1FF, "v00_01");
    tick();
    do_op(8'hFF, 8'hFF, 9'h000, "vFF_FF");
    tick();

    // start held high with changing operands during RUN.
    start = 1'b1;
    a     = 8'h35;
    b     = 8'h12;
    tick();
    a = 8'hAA;
    b = 8'h01;
    n = 0;
    pulses = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    start = 1'b0;
    if (done) pulses++;
    chk("hold_lat", n, 9);
    chk("hold_res", {23'd0, bout, diff}, 32'h023);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("hold_pulses", pulses, 1);

    // Reset in the fourth RUN cycle abandons the operation.
    start = 1'b1;
    a     = 8'h35;
    b     = 8'h12;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_diff", {24'd0, diff}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("mid_rst_pulses", pulses, 0);
    do_op(8'h5A, 8'h3C, 9'h01E, "after_rst");
    tick();

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    tick();

    // Back-to-back: second start in the done cycle of the first.
    do_op(8'h80, 8'h01, 9'h07F, "b2b1");
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h80;
    tick();
    start = 1'b0;
    n = 1;
    hold_ok = 1'b1;
    while (!done && n < 25) begin
      if (n <= 7 && diff !== 8'h7F) hold_ok = 1'b0;
      tick();
      n++;
    end
    chk("b2b_gap", n, 10);
    chk("b2b_hold", {31'd0, hold_ok}, 32'd1);
    chk("b2b2_res", {23'd0, bout, diff}, 32'h181);
    tick();

    // Random sweep against the golden model.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      model = {1'b0, ra} - {1'b0, rb};
      do_op(ra, rb, model, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
